// File: rtl/tdm_demux_4x1.sv
// Receive side of the 4-slot TDM link: tracks the slot sequence, collects samples
// into shadow registers and publishes a full frame on a, b, c, d with a valid strobe.
module tdm_demux_4x1 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic [WIDTH-1:0] din,
    output logic [1:0]       s,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             valid,
    output logic             frame_err,
    output logic             locked
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [1:0]       slot_r, slot_s;
    logic [WIDTH-1:0] sh0_r, sh1_r, sh2_r, sh3_r;
    logic [WIDTH-1:0] sh0_s, sh1_s, sh2_s, sh3_s;
    logic [WIDTH-1:0] a_r, b_r, c_r, d_r;
    logic [WIDTH-1:0] a_s, b_s, c_s, d_s;
    logic             valid_r, valid_s;
    logic             err_r, err_s;
    logic             locked_r, locked_s;

    // State, shadow and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            slot_r   <= 2'd0;
            sh0_r    <= '0;
            sh1_r    <= '0;
            sh2_r    <= '0;
            sh3_r    <= '0;
            a_r      <= '0;
            b_r      <= '0;
            c_r      <= '0;
            d_r      <= '0;
            valid_r  <= 1'b0;
            err_r    <= 1'b0;
            locked_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            slot_r   <= slot_s;
            sh0_r    <= sh0_s;
            sh1_r    <= sh1_s;
            sh2_r    <= sh2_s;
            sh3_r    <= sh3_s;
            a_r      <= a_s;
            b_r      <= b_s;
            c_r      <= c_s;
            d_r      <= d_s;
            valid_r  <= valid_s;
            err_r    <= err_s;
            locked_r <= locked_s;
        end
    end

    // Next-state, slot tracking, capture and publish decisions
    always_comb begin
        state_s = state_r;
        slot_s  = slot_r;
        sh0_s   = sh0_r;
        sh1_s   = sh1_r;
        sh2_s   = sh2_r;
        sh3_s   = sh3_r;
        a_s     = a_r;
        b_s     = b_r;
        c_s     = c_r;
        d_s     = d_r;
        valid_s = 1'b0;
        err_s   = 1'b0;
        if (en) begin
            case (state_r)
                ST_IDLE: begin
                    if (sync) begin
                        sh0_s   = din;
                        slot_s  = 2'd1;
                        state_s = ST_RUN;
                    end else begin
                        slot_s  = 2'd0;
                    end
                end
                ST_RUN: begin
                    if (slot_r == 2'd0) begin
                        if (sync) begin
                            sh0_s  = din;
                            slot_s = 2'd1;
                        end else begin
                            err_s   = 1'b1;
                            state_s = ST_IDLE;
                            slot_s  = 2'd0;
                        end
                    end else if (sync) begin
                        // Early marker: drop the partial frame, this sample starts a new one
                        err_s  = 1'b1;
                        sh0_s  = din;
                        slot_s = 2'd1;
                    end else begin
                        case (slot_r)
                            2'd1: begin
                                sh1_s  = din;
                                slot_s = 2'd2;
                            end
                            2'd2: begin
                                sh2_s  = din;
                                slot_s = 2'd3;
                            end
                            2'd3: begin
                                sh3_s   = din;
                                a_s     = sh0_r;
                                b_s     = sh1_r;
                                c_s     = sh2_r;
                                d_s     = din;
                                valid_s = 1'b1;
                                slot_s  = 2'd0;
                            end
                            default: begin
                                slot_s = 2'd0;
                            end
                        endcase
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    slot_s  = 2'd0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
        locked_s = (state_s == ST_RUN);
    end

    assign s         = slot_r;
    assign a         = a_r;
    assign b         = b_r;
    assign c         = c_r;
    assign d         = d_r;
    assign valid     = valid_r;
    assign frame_err = err_r;
    assign locked    = locked_r;

endmodule

// File: doc/tdm_demux_4x1.md
Name: tdm_demux_4x1

Overview:
- Receive end of the 4-slot time-division link driven by mux_4x1: one serial data lane plus a frame sync marker; the mux's select sequence 00→01→10→11 defines the slots.
- Tracks the current slot, captures each slot's sample into a shadow register, and publishes all four channels (a, b, c, d) together with a one-cycle valid strobe when a frame completes.
- Detects framing errors and resynchronises.

Parameters:
- WIDTH, 1, bit width of each slot sample and of each channel output.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- en  input  1  sample enable; a slot is consumed only on edges where en=1.
- sync  input  1  frame marker; high together with the slot-0 sample (s=00).
- din  input  WIDTH  serial slot data (the mux Y output).
- s  output  2  slot index expected on the next enabled edge (00..11).
- a  output  WIDTH  channel 0 (slot 00), last complete frame.
- b  output  WIDTH  channel 1 (slot 01), last complete frame.
- c  output  WIDTH  channel 2 (slot 10), last complete frame.
- d  output  WIDTH  channel 3 (slot 11), last complete frame.
- valid  output  1  one-cycle strobe: a, b, c, d just updated with a new frame.
- frame_err  output  1  one-cycle strobe: sync protocol violation detected.
- locked  output  1  high while in RUN state.

Behaviour:
- Reset (async, rst=1): state=IDLE, s=00, a=b=c=d=0, shadow registers=0, valid=0, frame_err=0, locked=0. Takes effect immediately, also mid-frame; any partial frame is discarded.
- en=0 edge: all state, s, shadow and outputs hold; valid and frame_err are forced to 0.
- State IDLE, enabled edge:
  - sync=1: capture din into shadow0, s←01, state←RUN.
  - sync=0: din is ignored, s stays 00, no error.
- State RUN, enabled edge with s=00:
  - sync=1: capture din into shadow0, s←01.
  - sync=0 (missing sync): frame_err=1, state←IDLE, s←00, sample discarded.
- State RUN, enabled edge with s=01/10: capture din into shadow1/shadow2, s←s+1.
- State RUN, enabled edge with s=11: capture din into shadow3.
  - On the same edge, a←shadow0, b←shadow1, c←shadow2, d←din.
  - valid=1 for the following cycle.
  - s wraps 11→00; state stays RUN.
- Unexpected sync in RUN with s≠00:
  - frame_err=1; the partial frame is dropped; a to d are not updated; valid=0.
  - The current din is taken as slot 0: shadow0←din, s←01, state stays RUN.
- Sync at s=11 is also an unexpected sync: resync as above; no frame is published.
- Latency: from the enabled edge sampling slot 11 to a–d valid is 0 cycles (they are registered on that edge); valid is high for the cycle after that edge.
- a to d change only on frame completion; they hold between frames and through errors.
- valid and frame_err are never high together; each lasts exactly one cycle per event.
- locked = (state==RUN), registered.
- Back-to-back frames with en=1 every cycle: valid=1 every 4th cycle, no dead cycle.

Test Plan:
- Reset then 4 enabled cycles of (sync,din) = (1,1),(0,0),(0,1),(0,1) → a=1, b=0, c=1, d=1; valid high exactly 1 cycle; s sequence 01,10,11,00; locked=1 from the first edge.
- Continuous frames 1000 / 0100 / 0010 / 0001 (a,b,c,d), matching the mux bench patterns → each frame published in order; valid every 4th cycle; frame_err never high.
- en toggled low for 3 cycles between slot 01 and slot 10 → s holds at 10; frame completes once en returns; values correct; valid=0 while en=0.
- sync=1 injected at s=10 → frame_err=1 one cycle; a to d keep the previous frame; s=01 next; the following 3 slots complete a frame with the injected din as a.
- sync=0 at an expected s=00 in RUN → frame_err=1, locked=0, s=00; din ignored until the next sync.
- rst pulsed asynchronously (between clock edges) mid-frame at s=10 → outputs zero immediately; no valid; after release, a fresh sync frame publishes correctly.
